// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
//   WIDTH  : operand width, fixed to the adder width
//   PROD_W : product width
//   CNT_W  : iteration counter width (holds 0..WIDTH)
package shift_add_mul_ctrl_pkg;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned PROD_W = 64;
  localparam int unsigned CNT_W  = 6;

  // 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Carry out of an MSB position, rebuilt from the operand MSBs and the sum MSB
  function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb ^ b_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// Start/busy/done handshake bundle between a requester and the multiplier.
//   start, clr, a, b : requester -> multiplier
//   busy, done, product : multiplier -> requester
interface shift_add_mul_ctrl_if;
  import shift_add_mul_ctrl_pkg::*;

  logic              start;
  logic              clr;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;

  modport master (output start, clr, a, b, input busy, done, product);
  modport slave  (input start, clr, a, b, output busy, done, product);

endinterface

// File: rtl/shift_add_mul_ctrl_adder.sv
// Sum-only ripple-carry adder, WIDTH bits, carry-in tied low.
//   a, b : addends
//   sum  : a + b truncated to WIDTH bits (no carry out)
module shift_add_mul_ctrl_adder
  import shift_add_mul_ctrl_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  // cy[i] is the carry into bit i; the carry out of the MSB is not built
  logic [WIDTH-1:0] cy;

  assign cy[0] = 1'b0;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    assign sum[i] = a[i] ^ b[i] ^ cy[i];
    if (i < int'(WIDTH) - 1) begin : g_cy
      assign cy[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & cy[i]);
    end
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequential 32x32 unsigned multiplier: one shared adder, 32 shift-add
// iterations, 64-bit product.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of shift_add_mul_ctrl_if
//                (start/clr/a/b in, busy/done/product out, all outputs registered)
module shift_add_mul_ctrl
  import shift_add_mul_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_add_mul_ctrl_if.slave bus
);

  state_e             state_q,   state_n;
  logic [WIDTH-1:0]   m_q,       m_n;
  logic [WIDTH-1:0]   acc_q,     acc_n;
  logic [WIDTH-1:0]   q_q,       q_n;
  logic [CNT_W-1:0]   cnt_q,     cnt_n;
  logic [PROD_W-1:0]  product_q, product_n;
  logic               busy_q,    busy_n;
  logic               done_q,    done_n;

  logic [WIDTH-1:0]   addend_c;
  logic [WIDTH-1:0]   sum_c;
  logic               carry_c;

  // Datapath: conditional addend, shared adder, carry rebuilt from MSBs
  assign addend_c = q_q[0] ? m_q : '0;

  shift_add_mul_ctrl_adder u_adder (
    .a   (acc_q),
    .b   (addend_c),
    .sum (sum_c)
  );

  assign carry_c = carry_out(acc_q[WIDTH-1], addend_c[WIDTH-1], sum_c[WIDTH-1]);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      m_q       <= m_n;
      acc_q     <= acc_n;
      q_q       <= q_n;
      cnt_q     <= cnt_n;
      product_q <= product_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  // Next state, iteration and registered-output decode
  always_comb begin
    state_n   = state_q;
    m_n       = m_q;
    acc_n     = acc_q;
    q_n       = q_q;
    cnt_n     = cnt_q;
    product_n = product_q;

    if (bus.clr) begin
      // Abort wins over start and over any in-flight iteration
      state_n   = IDLE;
      m_n       = '0;
      acc_n     = '0;
      q_n       = '0;
      cnt_n     = '0;
      product_n = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            m_n     = bus.a;
            q_n     = bus.b;
            acc_n   = '0;
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
        RUN: begin
          // {ACC,Q} <= {c,S,Q} >> 1
          acc_n = {carry_c, sum_c[WIDTH-1:1]};
          q_n   = {sum_c[0], q_q[WIDTH-1:1]};
          cnt_n = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_n   = DONE;
            product_n = {carry_c, sum_c, q_q[WIDTH-1:1]};
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed and random checks for shift_add_mul_ctrl.
module tb_shift_add_mul_ctrl;
  import shift_add_mul_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  shift_add_mul_ctrl_if bus ();

  shift_add_mul_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t        vecs [11];
  logic [63:0] last;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Present operands with a one-cycle start pulse (accepted at the next edge)
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Called right after the accepting edge; ends in the DONE cycle
  task automatic wait_done(input logic [63:0] exp, input logic [63:0] prior, input string tag);
    int   n;
    logic ovl;
    logic moved;
    n = 0; ovl = 1'b0; moved = 1'b0;
    while (bus.busy === 1'b1 && n < 40) begin
      if (bus.done !== 1'b0) ovl = 1'b1;
      if (bus.product !== prior) moved = 1'b1;
      tick();
      n++;
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd32);
    check({tag, " done_with_busy"}, 64'(ovl), 64'd0);
    check({tag, " product_moved_in_run"}, 64'(moved), 64'd0);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " product"}, bus.product, exp);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input logic [63:0] prior, input string tag);
    launch(a, b);
    wait_done(exp, prior, tag);
    tick();
    check({tag, " done_after"}, 64'(bus.done), 64'd0);
  endtask

  // Watch idle cycles for any unexpected done or busy
  task automatic quiet(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1;
      tick();
    end
    check({tag, " spurious_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'd7,         32'd6,         64'd42};
    vecs[1]  = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
    vecs[2]  = '{32'h80000000,  32'd2,         64'h1_00000000};
    vecs[3]  = '{32'd0,         32'h12345678,  64'd0};
    vecs[4]  = '{32'hDEADBEEF,  32'd0,         64'd0};
    vecs[5]  = '{32'd1,         32'd1,         64'd1};
    vecs[6]  = '{32'hFFFFFFFF,  32'd1,         64'h0000_0000_FFFF_FFFF};
    vecs[7]  = '{32'h00010000,  32'h00010000,  64'h1_00000000};
    vecs[8]  = '{32'hFFFFFFFF,  32'd2,         64'h1_FFFFFFFE};
    vecs[9]  = '{32'h80000000,  32'h80000000,  64'h40000000_00000000};
    vecs[10] = '{32'hFFFFFFFF,  32'h0000FFFF,  64'h0000_FFFE_FFFF_0001};

    // Reset held for three cycles
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.clr   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset product", bus.product, 64'd0);
    rst_n = 1'b1;
    tick();
    last = 64'd0;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, last, $sformatf("vec%0d", i));
      last = vecs[i].p;
    end

    // Start re-pulsed with new operands at RUN cycle 10 is ignored
    begin
      int n;
      launch(32'd7, 32'd6);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
        if (n == 10) begin
          bus.start = 1'b1;
          bus.a     = 32'd5;
          bus.b     = 32'd5;
        end else begin
          bus.start = 1'b0;
        end
        tick();
        n++;
      end
      bus.start = 1'b0;
      check("ignore busy_cycles", 64'(n), 64'd32);
      check("ignore done", 64'(bus.done), 64'd1);
      check("ignore product", bus.product, 64'd42);
      tick();
      last = 64'd42;
    end

    // Back-to-back: start during DONE begins the next op on the following cycle
    launch(32'd3, 32'd4);
    wait_done(64'd12, last, "b2b first");
    launch(32'd9, 32'd9);
    check("b2b busy_next", 64'(bus.busy), 64'd1);
    check("b2b done_next", 64'(bus.done), 64'd0);
    check("b2b product_held", bus.product, 64'd12);
    wait_done(64'd81, 64'd12, "b2b second");
    tick();
    check("b2b done_after", 64'(bus.done), 64'd0);
    last = 64'd81;

    // Synchronous abort at RUN cycle 15
    launch(32'd7, 32'd6);
    repeat (15) tick();
    check("clr busy_before", 64'(bus.busy), 64'd1);
    check("clr product_before", bus.product, 64'd81);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    check("clr busy", 64'(bus.busy), 64'd0);
    check("clr done", 64'(bus.done), 64'd0);
    check("clr product", bus.product, 64'd0);
    quiet(40, "clr");
    last = 64'd0;

    // Asynchronous reset in the middle of RUN
    run_op(32'd5, 32'd5, 64'd25, last, "pre_rst");
    launch(32'd6, 32'd7);
    repeat (10) tick();
    check("rst product_before", bus.product, 64'd25);
    rst_n = 1'b0;
    #1;
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    check("rst product", bus.product, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    quiet(40, "rst");
    last = 64'd0;

    // Random operands with periodic zero operands
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] rp;
      ra = $urandom();
      rb = $urandom();
      if (i % 50 == 0)  ra = '0;
      if (i % 50 == 25) rb = '0;
      rp = 64'(ra) * 64'(rb);
      run_op(ra, rb, rp, last, $sformatf("rnd%0d a=%0h b=%0h", i, ra, rb));
      last = rp;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
